// File: rtl/merlin_mem_arbiter.sv
// rtl/merlin_mem_arbiter.sv - shares one memory port between the I (fetch) and D (load/store) requesters
module merlin_mem_arbiter #(
  parameter int C_OUTSTANDING_X = 2,
  parameter int C_STARVE_LIMIT  = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        clk_en_i,
  input  logic        ireqvalid_i,
  output logic        ireqready_o,
  input  logic [1:0]  ireqhpl_i,
  input  logic [31:0] ireqaddr_i,
  output logic        irspvalid_o,
  input  logic        irspready_i,
  output logic        irsprerr_o,
  output logic [31:0] irspdata_o,
  input  logic        dreqvalid_i,
  output logic        dreqready_o,
  input  logic [1:0]  dreqhpl_i,
  input  logic [31:0] dreqaddr_i,
  input  logic        dreqwr_i,
  input  logic [1:0]  dreqsize_i,
  input  logic [31:0] dreqdata_i,
  output logic        drspvalid_o,
  input  logic        drspready_i,
  output logic        drsprerr_o,
  output logic [31:0] drspdata_o,
  output logic        mreqvalid_o,
  input  logic        mreqready_i,
  output logic [1:0]  mreqhpl_o,
  output logic [31:0] mreqaddr_o,
  output logic        mreqwr_o,
  output logic [1:0]  mreqsize_o,
  output logic [31:0] mreqdata_o,
  input  logic        mrspvalid_i,
  output logic        mrspready_o,
  input  logic        mrsprerr_i,
  input  logic [31:0] mrspdata_i,
  output logic        protocol_err_o
);
  localparam int AW = C_OUTSTANDING_X;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C = (AW+1)'(1);
  localparam logic [7:0] LIMIT_C = 8'(C_STARVE_LIMIT);

  // Tag FIFO: one bit per outstanding request, 0 = I, 1 = D
  logic [DEPTH-1:0] tag_q;
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [AW:0]      count_q;
  logic             lock_q, lock_sel_q, err_q;
  logic [7:0]       starve_q;

  logic empty, head_d, rsp_pop, pop, can_issue, lock_hold, sel_i, sel_d, issue;

  assign empty       = (count_q == '0);
  assign head_d      = tag_q[rd_ptr_q];
  assign mrspready_o = empty | (head_d ? drspready_i : irspready_i);
  assign rsp_pop     = mrspvalid_i & mrspready_o;
  assign pop         = rsp_pop & ~empty;
  assign can_issue   = (count_q < DEPTH_C) | ((count_q == DEPTH_C) & rsp_pop);

  assign irspvalid_o    = mrspvalid_i & ~empty & ~head_d;
  assign drspvalid_o    = mrspvalid_i & ~empty & head_d;
  assign irsprerr_o     = mrsprerr_i;
  assign drsprerr_o     = mrsprerr_i;
  assign irspdata_o     = mrspdata_i;
  assign drspdata_o     = mrspdata_i;
  assign protocol_err_o = err_q;

  // A stalled request keeps the port only while its requester still holds valid
  assign lock_hold = lock_q & (lock_sel_q ? dreqvalid_i : ireqvalid_i);

  always_comb begin
    sel_i = 1'b0;
    sel_d = 1'b0;
    if (lock_hold) begin
      sel_d = lock_sel_q;
      sel_i = ~lock_sel_q;
    end else if ((starve_q == LIMIT_C) && ireqvalid_i) begin
      sel_i = 1'b1;
    end else if (dreqvalid_i) begin
      sel_d = 1'b1;
    end else if (ireqvalid_i) begin
      sel_i = 1'b1;
    end
  end

  always_comb begin
    mreqhpl_o  = dreqhpl_i;
    mreqaddr_o = dreqaddr_i;
    mreqwr_o   = dreqwr_i;
    mreqsize_o = dreqsize_i;
    mreqdata_o = dreqdata_i;
    if (sel_i) begin
      mreqhpl_o  = ireqhpl_i;
      mreqaddr_o = {ireqaddr_i[31:2], 2'b00};
      mreqwr_o   = 1'b0;
      mreqsize_o = 2'b10;
      mreqdata_o = '0;
    end
  end

  assign mreqvalid_o = (sel_i | sel_d) & can_issue;
  assign ireqready_o = sel_i & mreqready_i & can_issue;
  assign dreqready_o = sel_d & mreqready_i & can_issue;
  assign issue       = mreqvalid_o & mreqready_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_sel_q <= 1'b0;
      starve_q   <= '0;
      err_q      <= 1'b0;
    end else if (clk_en_i) begin
      if (issue) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      if (issue && !pop)      count_q <= count_q + ONE_C;
      else if (!issue && pop) count_q <= count_q - ONE_C;
      lock_q     <= mreqvalid_o & ~mreqready_i;
      lock_sel_q <= sel_d;
      if ((issue && sel_i) || !ireqvalid_i) starve_q <= '0;
      else if (issue && sel_d && (starve_q < LIMIT_C)) starve_q <= starve_q + 8'd1;
      if (mrspvalid_i && empty) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i && clk_en_i && issue) tag_q[wr_ptr_q] <= sel_d;
  end
endmodule
